// File: rtl/sic_alu_lock_server_pkg.sv
// Shared types for the SIC ALU lock interface: op encodings, request/answer/lock
// records and the wrap-aware age comparison reused by age-ordered arbiters.
package sic_alu_lock_server_pkg;

   localparam int ID_MAX_W = 16;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } alu_op_e;

   typedef struct packed {
      alu_op_e     op;
      logic [31:0] a;
      logic [31:0] b;
   } alu_req_t;

   typedef struct packed {
      logic [31:0] c;
      logic        zero;
   } alu_ans_t;

   typedef struct packed {
      logic                req;
      logic [ID_MAX_W-1:0] req_issue_id;
      logic                release_lock;
   } alu_rpl_t;

   // x is older than y when (x - y) reduced to w bits is negative.
   function automatic logic id_older(input logic [31:0] x, input logic [31:0] y, input int w);
      logic [31:0] d;
      d = x - y;
      return d[5'(w - 1)];
   endfunction

endpackage

// File: rtl/sic_alu_lock_server_alu_core.sv
// Combinational shared ALU: evaluates one request and flags a zero result.
module alu_core
   import sic_alu_lock_server_pkg::*;
(
   input  alu_req_t req,
   output alu_ans_t ans
);

   logic [31:0] c_s;

   // Result select; shifts take data from b and the amount from a[4:0].
   always_comb begin
      c_s = 32'd0;
      case (req.op)
         ALU_ADD:  c_s = req.a + req.b;
         ALU_SUB:  c_s = req.a - req.b;
         ALU_AND:  c_s = req.a & req.b;
         ALU_OR:   c_s = req.a | req.b;
         ALU_XOR:  c_s = req.a ^ req.b;
         ALU_NOR:  c_s = ~(req.a | req.b);
         ALU_SLT:  c_s = {31'd0, ($signed(req.a) < $signed(req.b))};
         ALU_SLTU: c_s = {31'd0, (req.a < req.b)};
         ALU_SLL:  c_s = req.b << req.a[4:0];
         ALU_SRL:  c_s = req.b >> req.a[4:0];
         ALU_SRA:  c_s = $unsigned($signed(req.b) >>> req.a[4:0]);
         ALU_LUI:  c_s = {req.b[15:0], 16'h0000};
         default:  c_s = 32'd0;
      endcase
   end

   assign ans.c    = c_s;
   assign ans.zero = (c_s == 32'd0);

endmodule

// File: rtl/sic_alu_lock_server.sv
// ALU lock server: grants exclusive ALU ownership to the oldest requesting SIC
// and drives the owner's combinational ALU result back to every SIC.
module sic_alu_lock_server
   import sic_alu_lock_server_pkg::*;
#(
   parameter int NUM_SIC  = 4,
   parameter int ID_WIDTH = 4
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_SIC-1:0]           rpl_req,
   input  logic [NUM_SIC*ID_WIDTH-1:0]  rpl_issue_id,
   input  logic [NUM_SIC-1:0]           rpl_release,
   input  logic [NUM_SIC*4-1:0]         alu_op,
   input  logic [NUM_SIC*32-1:0]        alu_a,
   input  logic [NUM_SIC*32-1:0]        alu_b,
   output logic [NUM_SIC-1:0]           alu_grant,
   output logic [31:0]                  alu_c,
   output logic                         alu_zero,
   output logic [31:0]                  busy_cycles
);

   localparam int OWN_W = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 1;

   typedef enum logic {ST_FREE = 1'b0, ST_LOCKED = 1'b1} state_e;

   state_e             state_r, state_n;
   logic [OWN_W-1:0]   owner_r, owner_n, win_s;
   logic [NUM_SIC-1:0] grant_r, grant_n;
   logic [31:0]        busy_r;
   logic               found_s;
   alu_rpl_t           rpl_s [NUM_SIC];
   alu_req_t           req_s [NUM_SIC];
   alu_req_t           own_req_s;
   alu_ans_t           own_ans_s;

   // Unpack the flat per-SIC buses into records.
   always_comb begin
      for (int i = 0; i < NUM_SIC; i++) begin
         rpl_s[i].req          = rpl_req[i];
         rpl_s[i].req_issue_id = ID_MAX_W'(rpl_issue_id[i*ID_WIDTH +: ID_WIDTH]);
         rpl_s[i].release_lock = rpl_release[i];
         req_s[i].op           = alu_op_e'(alu_op[i*4 +: 4]);
         req_s[i].a            = alu_a[i*32 +: 32];
         req_s[i].b            = alu_b[i*32 +: 32];
      end
   end

   // Oldest requester; only a strictly older id displaces, so ties keep the lowest index.
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      for (int i = 0; i < NUM_SIC; i++) begin
         if (rpl_s[i].req && (!found_s ||
             id_older(32'(rpl_s[i].req_issue_id), 32'(rpl_s[win_s].req_issue_id), ID_WIDTH))) begin
            found_s = 1'b1;
            win_s   = OWN_W'(i);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Lock FSM next state; leaving LOCKED always passes through one FREE cycle.
   always_comb begin
      state_n = state_r;
      owner_n = owner_r;
      grant_n = grant_r;
      case (state_r)
         ST_FREE: begin
            if (found_s) begin
               state_n = ST_LOCKED;
               owner_n = win_s;
               grant_n = NUM_SIC'(1'b1) << win_s;
            end else begin
               state_n = ST_FREE;
            end
         end
         ST_LOCKED: begin
            if (rpl_s[owner_r].release_lock || !rpl_s[owner_r].req) begin
               state_n = ST_FREE;
               grant_n = '0;
            end else begin
               state_n = ST_LOCKED;
            end
         end
         default: begin
            state_n = ST_FREE;
            grant_n = '0;
         end
      endcase
   end

   // State, owner, grant and busy counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_FREE;
         owner_r <= '0;
         grant_r <= '0;
         busy_r  <= 32'd0;
      end else begin
         state_r <= state_n;
         owner_r <= owner_n;
         grant_r <= grant_n;
         busy_r  <= (state_r == ST_LOCKED) ? busy_r + 32'd1 : busy_r;
      end
   end

   // Owner operand mux; an all-zero ADD yields c=0 when nobody holds the lock.
   always_comb begin
      if (grant_r != '0) begin
         own_req_s = req_s[owner_r];
      end else begin
         own_req_s.op = ALU_ADD;
         own_req_s.a  = 32'd0;
         own_req_s.b  = 32'd0;
      end
   end

   alu_core u_alu_core (
      .req (own_req_s),
      .ans (own_ans_s)
   );

   assign alu_grant   = grant_r;
   assign alu_c       = own_ans_s.c;
   assign alu_zero    = own_ans_s.zero;
   assign busy_cycles = busy_r;

endmodule

// File: tb/tb_sic_alu_lock_server.sv
// Bench for sic_alu_lock_server: directed scenarios plus randomized traffic,
// checked every cycle against an ownership/ALU model and pinned literals.
module tb_sic_alu_lock_server;

   localparam int N  = 4;
   localparam int IW = 4;

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      rpl_req;
   logic [N*IW-1:0]   rpl_issue_id;
   logic [N-1:0]      rpl_release;
   logic [N*4-1:0]    alu_op;
   logic [N*32-1:0]   alu_a;
   logic [N*32-1:0]   alu_b;
   logic [N-1:0]      alu_grant;
   logic [31:0]       alu_c;
   logic              alu_zero;
   logic [31:0]       busy_cycles;

   int          errors = 0;
   int          checks = 0;
   int          m_owner = -1;
   logic [31:0] m_busy = 32'd0;
   logic [31:0] exp_c;

   logic        lit_grant_en = 1'b0, lit_c_en = 1'b0, lit_busy_en = 1'b0;
   logic [3:0]  lit_grant = 4'd0;
   logic [31:0] lit_c = 32'd0, lit_busy = 32'd0;
   logic        lit_zero = 1'b0;

   sic_alu_lock_server #(.NUM_SIC(N), .ID_WIDTH(IW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rpl_req      (rpl_req),
      .rpl_issue_id (rpl_issue_id),
      .rpl_release  (rpl_release),
      .alu_op       (alu_op),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_grant    (alu_grant),
      .alu_c        (alu_c),
      .alu_zero     (alu_zero),
      .busy_cycles  (busy_cycles)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return ~(a | b);
         4'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd7:    return (a < b) ? 32'd1 : 32'd0;
         4'd8:    return b << a[4:0];
         4'd9:    return b >> a[4:0];
         4'd10:   return 32'($signed(b) >>> a[4:0]);
         4'd11:   return {b[15:0], 16'h0000};
         default: return 32'd0;
      endcase
   endfunction

   function automatic bit older(input int x, input int y);
      return (((x - y) % (1 << IW) + (1 << IW)) % (1 << IW)) >= (1 << (IW - 1));
   endfunction

   function automatic int id_of(input int i);
      return int'(rpl_issue_id[i*IW +: IW]);
   endfunction

   // Oldest candidate; ties go to the lower index.
   function automatic int pick_winner();
      for (int i = 0; i < N; i++) begin
         if (rpl_req[i]) begin
            bit ok = 1'b1;
            for (int j = 0; j < N; j++) begin
               if (j != i && rpl_req[j] &&
                   (older(id_of(j), id_of(i)) || (id_of(j) == id_of(i) && j < i)))
                  ok = 1'b0;
            end
            if (ok) return i;
         end
      end
      return -1;
   endfunction

   // Ownership model: owner -1 means the lock is free.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner <= -1;
         m_busy  <= 32'd0;
      end else if (m_owner < 0) begin
         m_owner <= pick_winner();
      end else begin
         m_busy <= m_busy + 32'd1;
         if (rpl_release[m_owner] || !rpl_req[m_owner]) m_owner <= -1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Single compare process, sampled on the falling edge.
   always @(negedge clk) begin
      exp_c = (m_owner >= 0) ? ref_alu(alu_op[m_owner*4 +: 4], alu_a[m_owner*32 +: 32],
                                       alu_b[m_owner*32 +: 32]) : 32'd0;
      chk("grant", 32'(alu_grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("alu_c", alu_c, exp_c);
      chk("alu_zero", 32'(alu_zero), (exp_c == 32'd0) ? 32'd1 : 32'd0);
      chk("busy", busy_cycles, m_busy);
      if (lit_grant_en) chk("lit_grant", 32'(alu_grant), 32'(lit_grant));
      if (lit_c_en) begin
         chk("lit_c", alu_c, lit_c);
         chk("lit_zero", 32'(alu_zero), 32'(lit_zero));
      end
      if (lit_busy_en) chk("lit_busy", busy_cycles, lit_busy);
   end

   task automatic tick();
      @(posedge clk);
      #1;
      lit_grant_en = 1'b0;
      lit_c_en     = 1'b0;
      lit_busy_en  = 1'b0;
   endtask

   task automatic pin_grant(input logic [3:0] g);
      lit_grant = g; lit_grant_en = 1'b1;
   endtask

   task automatic pin_c(input logic [31:0] c, input logic z);
      lit_c = c; lit_zero = z; lit_c_en = 1'b1;
   endtask

   task automatic pin_busy(input logic [31:0] b);
      lit_busy = b; lit_busy_en = 1'b1;
   endtask

   task automatic set_sic(input int i, input logic r, input logic [3:0] id, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
      rpl_req[i]              = r;
      rpl_issue_id[i*IW +: IW] = id;
      alu_op[i*4 +: 4]        = op;
      alu_a[i*32 +: 32]       = a;
      alu_b[i*32 +: 32]       = b;
   endtask

   initial begin
      int base;
      rst_n = 1'b0;
      rpl_req = '0; rpl_issue_id = '0; rpl_release = '0;
      alu_op = '0; alu_a = '0; alu_b = '0;
      pin_grant(4'd0); pin_c(32'd0, 1'b1); pin_busy(32'd0);
      tick();
      pin_grant(4'd0); pin_c(32'd0, 1'b1); pin_busy(32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // single requester
      set_sic(2, 1'b1, 4'd3, 4'd0, 32'd7, 32'd5);
      pin_grant(4'd0);
      tick();
      pin_grant(4'b0100); pin_c(32'd12, 1'b0);
      rpl_release[2] = 1'b1; rpl_req[2] = 1'b0;
      tick();
      rpl_release = '0;
      pin_grant(4'd0); pin_c(32'd0, 1'b1);
      tick();

      // age arbitration
      set_sic(0, 1'b1, 4'd5, 4'd0, 32'd1, 32'd2);
      set_sic(1, 1'b1, 4'd3, 4'd0, 32'd3, 32'd4);
      tick();
      pin_grant(4'b0010); pin_c(32'd7, 1'b0);
      rpl_release[1] = 1'b1; rpl_req[1] = 1'b0;
      tick();
      rpl_release = '0;
      pin_grant(4'd0);
      tick();
      pin_grant(4'b0001); pin_c(32'd3, 1'b0);
      rpl_release[0] = 1'b1; rpl_req[0] = 1'b0;
      tick();
      rpl_release = '0;
      pin_grant(4'd0);
      tick();

      // wrap-around age and ALU ops on the owner
      set_sic(0, 1'b1, 4'd14, 4'd1, 32'd5, 32'd5);
      set_sic(3, 1'b1, 4'd1, 4'd0, 32'd0, 32'd0);
      tick();
      pin_grant(4'b0001); pin_c(32'd0, 1'b1);
      tick();
      set_sic(0, 1'b1, 4'd14, 4'd6, 32'hFFFF_FFFF, 32'd1);
      pin_grant(4'b0001); pin_c(32'd1, 1'b0);
      tick();
      set_sic(0, 1'b1, 4'd14, 4'd7, 32'hFFFF_FFFF, 32'd1);
      pin_c(32'd0, 1'b1);
      tick();
      set_sic(0, 1'b1, 4'd14, 4'd10, 32'd4, 32'h8000_0000);
      pin_c(32'hF800_0000, 1'b0);
      tick();
      set_sic(0, 1'b1, 4'd14, 4'd11, 32'h0000_0077, 32'h0000_1234);
      pin_c(32'h1234_0000, 1'b0);

      // non-owner release is ignored, then owner aborts
      rpl_release[1] = 1'b1;
      tick();
      rpl_release = '0;
      pin_grant(4'b0001);
      rpl_req[0] = 1'b0;
      tick();
      pin_grant(4'd0);
      tick();
      pin_grant(4'b1000);
      rpl_req[3] = 1'b0;
      tick();
      tick();

      // reset while locked with busy_cycles at 9
      rst_n = 1'b0;
      pin_busy(32'd0);
      tick();
      rst_n = 1'b1;
      set_sic(1, 1'b1, 4'd0, 4'd3, 32'h0000_00F0, 32'h0000_000F);
      tick();
      repeat (9) tick();
      pin_grant(4'b0010); pin_busy(32'd9); pin_c(32'h0000_00FF, 1'b0);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      pin_grant(4'd0); pin_busy(32'd0); pin_c(32'd0, 1'b1);
      tick();
      rst_n = 1'b1;
      tick();
      pin_grant(4'b0010); pin_busy(32'd0);
      rpl_req = '0;
      tick();
      tick();

      // randomized traffic; live ids stay within a window of 8 so age is a total order
      for (int seg = 0; seg < 8; seg++) begin
         base = int'($urandom_range(0, 15));
         repeat (250) begin
            for (int i = 0; i < N; i++) begin
               if (rpl_req[i]) begin
                  if ($urandom_range(0, 9) == 0) rpl_req[i] = 1'b0;
               end else if ($urandom_range(0, 3) == 0) begin
                  rpl_req[i] = 1'b1;
                  rpl_issue_id[i*IW +: IW] = 4'(base + int'($urandom_range(0, 7)));
               end
               rpl_release[i] = ($urandom_range(0, 4) == 0);
               alu_op[i*4 +: 4] = 4'($urandom_range(0, 15));
               alu_a[i*32 +: 32] = $urandom;
               alu_b[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? alu_a[i*32 +: 32] : $urandom;
            end
            tick();
         end
         rpl_req = '0;
         rpl_release = '0;
         tick();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
